// File: rtl/cpu_seq_core.sv
// Stored-program sequencer: loadable instruction memory, four general registers
// and a two-cycle fetch/execute FSM that runs a program to HALT under chip-select.
//
// state | meaning
// IDLE  | waiting; instruction load or run-start accepted
// FETCH | IR <= imem[PC]
// EXEC  | execute IR, update registers/ALURESULT/PC
// HALT  | program finished; load or restart accepted
module cpu_seq_core #(
    parameter int DATA_W  = 8,
    parameter int INSTR_W = 9,
    parameter int ADDR_W  = 4
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [INSTR_W-1:0] INSTRUCTION,
    input  logic               write_en,
    input  logic               RD,
    input  logic               CS,
    input  logic [DATA_W-1:0]  INALU,
    output logic [ADDR_W-1:0]  PC,
    output logic [DATA_W-1:0]  ALURESULT,
    output logic               BUSY,
    output logic               DONE
);

    localparam int IMEM_DEPTH = 2 ** ADDR_W;
    localparam int IMM_W      = INSTR_W - 5;
    localparam int EXT_W      = (IMM_W > DATA_W) ? IMM_W : DATA_W;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_LDI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_IN  = 3'b110;
    localparam logic [2:0] OP_SYS = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [INSTR_W-1:0] imem [IMEM_DEPTH];
    logic [INSTR_W-1:0] ir;
    logic [DATA_W-1:0]  regs [4];
    logic [ADDR_W-1:0]  lp;

    logic [ADDR_W-1:0]  pc_nxt;
    logic [ADDR_W-1:0]  lp_nxt;
    logic [DATA_W-1:0]  alu_nxt;
    logic [DATA_W-1:0]  wr_val;
    logic               reg_we;
    logic               ir_load;
    logic               imem_we;

    logic [2:0]         opcode;
    logic [1:0]         rd_idx;
    logic [1:0]         rs_idx;
    logic [IMM_W-1:0]   imm;
    logic [EXT_W-1:0]   imm_wide;
    logic [DATA_W-1:0]  imm_ext;
    logic [DATA_W-1:0]  rd_val;
    logic [DATA_W-1:0]  rs_val;

    assign opcode   = ir[INSTR_W-1 -: 3];
    assign rd_idx   = ir[INSTR_W-4 -: 2];
    assign imm      = ir[IMM_W-1:0];
    assign rs_idx   = imm[1:0];
    assign imm_wide = EXT_W'(imm);
    assign imm_ext  = imm_wide[DATA_W-1:0];
    assign rd_val   = regs[rd_idx];
    assign rs_val   = regs[rs_idx];

    assign BUSY = (state == FETCH) || (state == EXEC);
    assign DONE = (state == HALT);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // All next-state decisions are gated by CS so a deselected core holds everything.
    always_comb begin
        state_nxt = state;
        pc_nxt    = PC;
        lp_nxt    = lp;
        alu_nxt   = ALURESULT;
        wr_val    = '0;
        reg_we    = 1'b0;
        ir_load   = 1'b0;
        imem_we   = 1'b0;
        if (CS) begin
            case (state)
                IDLE, HALT: begin
                    if (write_en) begin
                        imem_we = 1'b1;
                        lp_nxt  = lp + ADDR_W'(1);
                    end else if (RD) begin
                        pc_nxt    = '0;
                        lp_nxt    = '0;
                        state_nxt = FETCH;
                    end
                end
                FETCH: begin
                    ir_load   = 1'b1;
                    state_nxt = EXEC;
                end
                EXEC: begin
                    pc_nxt    = PC + ADDR_W'(1);
                    state_nxt = FETCH;
                    case (opcode)
                        OP_NOP: ;
                        OP_LDI: begin wr_val = imm_ext;         reg_we = 1'b1; end
                        OP_ADD: begin wr_val = rd_val + rs_val; reg_we = 1'b1; end
                        OP_SUB: begin wr_val = rd_val - rs_val; reg_we = 1'b1; end
                        OP_AND: begin wr_val = rd_val & rs_val; reg_we = 1'b1; end
                        OP_XOR: begin wr_val = rd_val ^ rs_val; reg_we = 1'b1; end
                        OP_IN:  begin wr_val = INALU;           reg_we = 1'b1; end
                        OP_SYS: begin
                            if (imm == '0) begin
                                pc_nxt    = PC;
                                state_nxt = HALT;
                            end else if (ALURESULT != '0) begin
                                pc_nxt = imm[ADDR_W-1:0];
                            end
                        end
                        default: ;
                    endcase
                    if (reg_we) begin
                        alu_nxt = wr_val;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            PC        <= '0;
            ALURESULT <= '0;
            lp        <= '0;
            ir        <= '0;
            for (int i = 0; i < 4; i++) begin
                regs[i] <= '0;
            end
        end else begin
            PC        <= pc_nxt;
            ALURESULT <= alu_nxt;
            lp        <= lp_nxt;
            if (ir_load) begin
                ir <= imem[PC];
            end
            if (reg_we) begin
                regs[rd_idx] <= wr_val;
            end
        end
    end

    // Program memory keeps its contents across reset so a restart reruns the old program.
    always_ff @(posedge CLK) begin
        if (imem_we) begin
            imem[lp] <= INSTRUCTION;
        end
    end

endmodule
